// File: rtl/qpsk_byte_feeder.sv
// Byte feeder for the QPSK modulator: buffers source bytes in a FIFO and issues
// one byte per BYTE_PERIOD clocks, substituting IDLE_BYTE and flagging underrun when dry.
module qpsk_byte_feeder #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BYTE_PERIOD = 32,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               data,
  output logic                     ld,
  output logic                     busy,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTE_PERIOD - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic load;
  logic empty;

  assign in_ready = (count != FULL);
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  // en is only looked at on a load instant, so a period in progress always completes
  assign load     = en && ((state == IDLE) || (cnt == LAST));
  assign pop      = load && !empty;
  assign level    = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data     <= '0;
      ld       <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ld       <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!en) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // A byte pushed into an empty FIFO on this edge is not bypassed
      if (load) begin
        ld <= 1'b1;
        if (empty) begin
          data     <= IDLE_BYTE;
          underrun <= 1'b1;
        end else begin
          data     <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_byte_feeder.sv
// Randomized and directed bench for qpsk_byte_feeder against a time-based queue model.
module tb_qpsk_byte_feeder;

  localparam int P = 32;
  localparam int D = 8;
  localparam logic [7:0] IDLE_B = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       ld;
  logic       busy;
  logic       underrun;
  logic [3:0] level;

  qpsk_byte_feeder #(.DEPTH(D), .BYTE_PERIOD(P), .IDLE_BYTE(IDLE_B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .ld       (ld),
    .busy     (busy),
    .underrun (underrun),
    .level    (level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: FIFO contents as a queue, and the absolute cycle of the next load instant
  logic [7:0] q[$];
  bit         running;
  int         cyc;
  int         next_load;
  logic [7:0] e_data;
  bit         e_ld;
  bit         e_ud;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_ld"},       ld,       e_ld);
    check({tag, "_data"},     data,     e_data);
    check({tag, "_underrun"}, underrun, e_ud);
    check({tag, "_busy"},     busy,     running);
    check({tag, "_level"},    level,    q.size());
  endtask

  task automatic model_reset();
    q.delete();
    running = 0;
    e_data  = 8'h00;
    e_ld    = 0;
    e_ud    = 0;
  endtask

  task automatic model_edge(input bit e, input bit v, input logic [7:0] d);
    bit load = 0;
    bit push_ok;
    cyc++;
    push_ok = v && (q.size() < D);
    if (!running) begin
      if (e) begin
        running   = 1;
        load      = 1;
        next_load = cyc + P;
      end
    end else if (cyc == next_load) begin
      if (e) begin
        load      = 1;
        next_load = next_load + P;
      end else begin
        running = 0;
      end
    end
    e_ld = load;
    e_ud = 0;
    if (load) begin
      if (q.size() > 0) begin
        e_data = q.pop_front();
      end else begin
        e_data = IDLE_B;
        e_ud   = 1;
      end
    end
    if (push_ok) q.push_back(d);
  endtask

  task automatic step(input bit e, input bit v, input logic [7:0] d);
    @(negedge clk);
    en = e; in_valid = v; in_data = d;
    #1 check("in_ready", in_ready, q.size() < D);
    @(posedge clk);
    model_edge(e, v, d);
    #1 check_outs("cyc");
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    en = 0; in_valid = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_outs("async_rst");
    check("async_rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [7:0] plan [3];
    int  rate;
    bit  ren;
    plan[0] = 8'hA5; plan[1] = 8'h3C; plan[2] = 8'hF0;
    cyc = 0; next_load = 0;
    rst_n = 0; en = 0; in_valid = 0; in_data = 8'h00;
    model_reset();
    #12;
    check_outs("reset");
    check("reset_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;

    // Fill while disabled
    for (int i = 0; i < 3; i++) step(0, 1, plan[i]);
    repeat (3) step(0, 0, 8'h00);
    check("plan_level3", level, 3);
    check("plan_ready", in_ready, 1);
    check("plan_noload_data", data, 8'h00);

    // Enable: bytes come out one per period
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'h00);
      check("plan_ld", ld, 1);
      check("plan_byte", data, plan[i]);
      check("plan_level", level, 2 - i);
      repeat (P - 1) step(1, 0, 8'h00);
    end

    // Dry FIFO: idle byte with underrun, push on the same edge is not bypassed
    step(1, 1, 8'h77);
    check("dry_underrun", underrun, 1);
    check("dry_data", data, IDLE_B);
    repeat (P - 1) step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    check("after_dry_data", data, 8'h77);
    check("after_dry_underrun", underrun, 0);

    // Stop at the next load instant, then fill to full
    repeat (P) step(0, 0, 8'h00);
    check("stopped_busy", busy, 0);
    for (int i = 0; i < D; i++) step(0, 1, 8'h10 + 8'(i));
    repeat (4) step(0, 1, 8'h99);
    check("full_level", level, D);
    check("full_ready", in_ready, 0);
    step(1, 1, 8'h99);
    check("full_first_pop", data, 8'h10);
    check("full_ready_after_pop", in_ready, 1);
    repeat (D * P) step(1, 0, 8'h00);

    // Drop en mid-period: period completes, then no further load
    for (int i = 0; i < P + 1; i++) begin
      if (ld) break;
      step(1, 0, 8'h00);
    end
    check("resync_ld", ld, 1);
    repeat (9) step(1, 0, 8'h00);
    repeat (3 * P) step(0, 0, 8'h00);
    check("drop_busy", busy, 0);
    check("drop_ld", ld, 0);

    // Reset while running with four bytes buffered
    step(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 1, 8'hC0 + 8'(i));
    check("prerst_level", level, 4);
    pulse_reset();
    step(1, 0, 8'h00);
    check("postrst_underrun", underrun, 1);
    check("postrst_data", data, IDLE_B);

    // Randomized traffic with varying fill rates and occasional resets
    rate = 16;
    ren  = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) rate = ($urandom_range(0, 1) == 1) ? 12 : 64;
      if ($urandom_range(0, 79) == 0) ren = ~ren;
      if ($urandom_range(0, 1499) == 0) pulse_reset();
      step(ren, $urandom_range(0, rate - 1) < 3, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
